// File: rtl/risp_run_ctrl_if.sv
// Purpose: host-side command stream and output fire-vector stream of risp_run_ctrl.
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_idx/cmd_arg : command handshake (host -> controller)
//   out_valid/out_ready/out_fires              : per-timestep fire vector (controller -> host)
//   out_counts                                 : saturating per-output fire counts of the run
//   run_done                                   : one-cycle pulse when a RUN completes
// Modports: master = host side, slave = controller side.
interface risp_run_ctrl_if #(
    parameter int unsigned NUM_INP   = 4,
    parameter int unsigned NUM_OUT   = 4,
    parameter int unsigned RUN_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 8
);
    localparam int unsigned IDX_W = (NUM_INP > 1) ? $clog2(NUM_INP) : 1;

    logic                                cmd_valid;
    logic                                cmd_ready;
    logic [1:0]                          cmd_op;
    logic [IDX_W-1:0]                    cmd_idx;
    logic [RUN_WIDTH-1:0]                cmd_arg;
    logic                                out_valid;
    logic                                out_ready;
    logic [NUM_OUT-1:0]                  out_fires;
    logic [NUM_OUT-1:0][CNT_WIDTH-1:0]   out_counts;
    logic                                run_done;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_arg, out_ready,
        input  cmd_ready, out_valid, out_fires, out_counts, run_done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_arg, out_ready,
        output cmd_ready, out_valid, out_fires, out_counts, run_done
    );
endinterface

// File: rtl/risp_run_ctrl.sv
// Purpose: sequences a RISP neuron network. Buffers input spike charges from the
// command stream, issues one net_en per timestep, streams each timestep's fire
// vector to the host with backpressure and keeps saturating per-output fire counts.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : command / output streams (risp_run_ctrl_if.slave)
//   net_en     : timestep enable, asserted in the cycle a step fires
//   net_inp    : signed per-input charge, pending charges on a firing step, else 0
//   net_clear  : one-cycle network state clear request
//   net_fire   : network output fires, sampled in the net_en cycle
module risp_run_ctrl #(
    parameter int unsigned NUM_INP      = 4,
    parameter int unsigned NUM_OUT      = 4,
    parameter int unsigned CHARGE_WIDTH = 8,
    parameter int unsigned RUN_WIDTH    = 16,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    risp_run_ctrl_if.slave                         bus,
    output logic                                   net_en,
    output logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]   net_inp,
    output logic                                   net_clear,
    input  logic [NUM_OUT-1:0]                     net_fire
);
    localparam int unsigned IDX_W = (NUM_INP > 1) ? $clog2(NUM_INP) : 1;

    localparam logic [1:0] OP_SPIKE = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]   pend_q;
    logic [RUN_WIDTH-1:0]                   remaining_q;
    logic [NUM_OUT-1:0][CNT_WIDTH-1:0]      counts_q;
    logic [NUM_OUT-1:0]                     fires_q;
    logic                                   out_valid_q;
    logic                                   run_done_q;

    logic cmd_fire_c;
    logic step_c;
    logic last_c;
    logic run_zero_c;

    // Signed add of two CHARGE_WIDTH values, clamped to the representable range.
    function automatic logic [CHARGE_WIDTH-1:0] sat_add(
        input logic [CHARGE_WIDTH-1:0] a,
        input logic [CHARGE_WIDTH-1:0] b
    );
        logic [CHARGE_WIDTH:0] s;
        s = {a[CHARGE_WIDTH-1], a} + {b[CHARGE_WIDTH-1], b};
        if (s[CHARGE_WIDTH] != s[CHARGE_WIDTH-1]) begin
            // Overflow: the extra sign bit gives the true direction.
            sat_add = s[CHARGE_WIDTH] ? {1'b1, {(CHARGE_WIDTH-1){1'b0}}}
                                      : {1'b0, {(CHARGE_WIDTH-1){1'b1}}};
        end else begin
            sat_add = s[CHARGE_WIDTH-1:0];
        end
    endfunction

    // Handshake qualifiers. rst gates everything combinational so nothing leaks
    // out during the reset cycle itself.
    assign cmd_fire_c = bus.cmd_valid && bus.cmd_ready;
    assign step_c     = (state_q == ST_STEP) && (!out_valid_q || bus.out_ready) && !rst;
    assign last_c     = step_c && (remaining_q == RUN_WIDTH'(1));
    assign run_zero_c = cmd_fire_c && (bus.cmd_op == OP_RUN) && (bus.cmd_arg == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire_c) begin
                    if (bus.cmd_op == OP_RUN && bus.cmd_arg != '0) begin
                        state_d = ST_STEP;
                    end else if (bus.cmd_op == OP_CLEAR) begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_STEP: begin
                if (last_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic. net_en/net_inp follow out_ready in the same cycle so a
    // step can fire while the previous vector is being taken.
    always_comb begin
        net_en        = 1'b0;
        net_inp       = '0;
        net_clear     = 1'b0;
        bus.cmd_ready = 1'b0;
        if (step_c) begin
            net_en  = 1'b1;
            net_inp = pend_q;
        end
        if (state_q == ST_CLEAR && !rst) begin
            net_clear = 1'b1;
        end
        if (state_q == ST_IDLE && !rst) begin
            bus.cmd_ready = 1'b1;
        end
    end

    // Datapath: pending charges, step counter, fire vector and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            remaining_q <= '0;
            counts_q    <= '0;
            fires_q     <= '0;
            out_valid_q <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            run_done_q <= last_c || run_zero_c;

            if (cmd_fire_c) begin
                unique case (bus.cmd_op)
                    OP_SPIKE: begin
                        for (int i = 0; i < int'(NUM_INP); i++) begin
                            if (bus.cmd_idx == IDX_W'(i)) begin
                                pend_q[i] <= sat_add(pend_q[i], bus.cmd_arg[CHARGE_WIDTH-1:0]);
                            end
                        end
                    end
                    OP_RUN: begin
                        remaining_q <= bus.cmd_arg;
                        counts_q    <= '0;
                    end
                    OP_CLEAR: pend_q <= '0;
                    default: ;
                endcase
            end

            if (step_c) begin
                // Only the first step of a run carries the buffered charges.
                pend_q      <= '0;
                remaining_q <= remaining_q - RUN_WIDTH'(1);
                fires_q     <= net_fire;
                out_valid_q <= 1'b1;
                for (int i = 0; i < int'(NUM_OUT); i++) begin
                    if (net_fire[i] && counts_q[i] != '1) begin
                        counts_q[i] <= counts_q[i] + CNT_WIDTH'(1);
                    end
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_fires  = fires_q;
    assign bus.out_counts = counts_q;
    assign bus.run_done   = run_done_q;

endmodule

// File: tb/tb_risp_run_ctrl.sv
// Bench for risp_run_ctrl: directed command sequences; expected net_inp values,
// fire vectors and run_done counts are queued and checked by a negedge monitor.
module tb_risp_run_ctrl;
    localparam int unsigned NI = 4;
    localparam int unsigned NO = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned RW = 16;
    localparam int unsigned KW = 8;

    localparam logic [1:0] OP_SPIKE = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef struct packed {
        logic [NO*KW-1:0] counts;
        logic             after_step;
    } done_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       net_en;
    logic                       net_clear;
    logic [NI-1:0][CW-1:0]      net_inp;
    logic [NO-1:0]              net_fire;

    risp_run_ctrl_if #(.NUM_INP(NI), .NUM_OUT(NO), .RUN_WIDTH(RW), .CNT_WIDTH(KW)) bus ();

    risp_run_ctrl #(
        .NUM_INP(NI), .NUM_OUT(NO), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW), .CNT_WIDTH(KW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .net_en    (net_en),
        .net_inp   (net_inp),
        .net_clear (net_clear),
        .net_fire  (net_fire)
    );

    always #5 clk = ~clk;

    logic [NI*CW-1:0] exp_inp_q[$];
    logic [NO-1:0]    exp_fire_q[$];
    done_t            exp_done_q[$];
    done_t            mon_d;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int vec_cnt = 0;
    int done_cnt = 0;
    int clr_cnt = 0;
    int cyc = 0;
    int last_en_cyc = -10;
    bit prev_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: every DUT-presented output is matched against the queues.
    always @(negedge clk) begin
        cyc++;
        if (bus.out_valid && bus.out_ready) begin
            vec_cnt++;
            if (exp_fire_q.size() == 0) fail_now("unexpected_vector");
            else chk("out_fires", 64'(bus.out_fires), 64'(exp_fire_q.pop_front()));
        end
        if (prev_en) chk("out_valid_after_step", 64'(bus.out_valid), 64'd1);
        prev_en = net_en;
        if (net_en) begin
            en_cnt++;
            last_en_cyc = cyc;
            if (exp_inp_q.size() == 0) fail_now("unexpected_net_en");
            else chk("net_inp", 64'(net_inp), 64'(exp_inp_q.pop_front()));
            exp_fire_q.push_back(net_fire);
        end
        if (net_en || net_clear) chk("en_clear_exclusive", 64'(net_en && net_clear), 64'd0);
        if (net_clear) clr_cnt++;
        if (bus.run_done) begin
            done_cnt++;
            if (exp_done_q.size() == 0) begin
                fail_now("unexpected_run_done");
            end else begin
                mon_d = exp_done_q.pop_front();
                chk("out_counts", 64'(bus.out_counts), 64'(mon_d.counts));
                if (mon_d.after_step) chk("run_done_latency", 64'(last_en_cyc), 64'(cyc - 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_done(input logic [NO*KW-1:0] counts, input logic after_step);
        done_t d;
        d.counts = counts;
        d.after_step = after_step;
        exp_done_q.push_back(d);
    endtask

    // Hold a command until accepted; returns 1 time unit after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input int idx, input logic [RW-1:0] arg);
        bit ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_idx   = 2'(idx);
        bus.cmd_arg   = arg;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (!ok) fail_now("cmd_accept_timeout");
    endtask

    task automatic wait_en(input int target);
        for (int n = 0; n < 2000; n++) begin
            if (en_cnt >= target) break;
            @(posedge clk);
        end
        #1;
        if (en_cnt < target) fail_now("net_en_timeout");
    endtask

    task automatic wait_done(input int target);
        for (int n = 0; n < 2000; n++) begin
            if (done_cnt >= target) break;
            @(posedge clk);
        end
        #1;
        if (done_cnt < target) fail_now("run_done_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int vbase;
        int dbase;
        int cbase;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd3;
        bus.cmd_idx   = '0;
        bus.cmd_arg   = '0;
        bus.out_ready = 1'b1;
        net_fire      = '0;
        rst           = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_net_en", 64'(net_en), 64'd0);
        chk("rst_net_clear", 64'(net_clear), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_run_done", 64'(bus.run_done), 64'd0);
        chk("rst_out_fires", 64'(bus.out_fires), 64'd0);
        chk("rst_out_counts", 64'(bus.out_counts), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'd1);
        tick();

        // 1: two spikes accumulate, single-step run
        exp_inp_q.push_back(32'h0000_0008);
        push_done('0, 1'b1);
        send_cmd(OP_SPIKE, 0, 16'd5);
        send_cmd(OP_SPIKE, 0, 16'd3);
        send_cmd(OP_RUN, 0, 16'd1);
        wait_done(1);
        repeat (2) tick();

        // 2: positive and negative charge saturation
        exp_inp_q.push_back(32'h0080_7F00);
        push_done('0, 1'b1);
        send_cmd(OP_SPIKE, 1, 16'd100);
        send_cmd(OP_SPIKE, 1, 16'd100);
        send_cmd(OP_SPIKE, 2, 16'h0080);
        send_cmd(OP_SPIKE, 2, 16'h0080);
        send_cmd(OP_RUN, 0, 16'd1);
        wait_done(2);
        repeat (2) tick();

        // 3: backpressure after the first step of RUN 4
        base  = en_cnt;
        vbase = vec_cnt;
        dbase = done_cnt;
        for (int i = 0; i < 4; i++) exp_inp_q.push_back('0);
        push_done(32'h0001_0304, 1'b1);
        bus.out_ready = 1'b0;
        net_fire = 4'b0101;
        send_cmd(OP_RUN, 0, 16'd4);
        wait_en(base + 1);
        net_fire = 4'b0011;
        repeat (8) tick();
        @(negedge clk);
        chk("stall_one_step", 64'(en_cnt), 64'(base + 1));
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_out_fires", 64'(bus.out_fires), 64'h5);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_done(dbase + 1);
        chk("run4_steps", 64'(en_cnt), 64'(base + 4));
        chk("run4_vectors", 64'(vec_cnt), 64'(vbase + 4));
        repeat (3) tick();
        chk("run4_done_once", 64'(done_cnt), 64'(dbase + 1));

        // 4: counter saturation over RUN 300, then RUN 0
        net_fire = 4'b0001;
        for (int i = 0; i < 300; i++) exp_inp_q.push_back('0);
        push_done(32'h0000_00FF, 1'b1);
        send_cmd(OP_RUN, 0, 16'd300);
        wait_done(dbase + 2);
        repeat (2) tick();
        base = en_cnt;
        push_done('0, 1'b0);
        send_cmd(OP_RUN, 0, 16'd0);
        wait_done(dbase + 3);
        repeat (3) tick();
        chk("run0_no_net_en", 64'(en_cnt), 64'(base));
        net_fire = '0;

        // 5: CLEAR drops pending spikes and pulses net_clear once
        cbase = clr_cnt;
        send_cmd(OP_SPIKE, 0, 16'd7);
        send_cmd(OP_SPIKE, 3, 16'd2);
        send_cmd(OP_CLEAR, 0, 16'd0);
        @(negedge clk);
        chk("clear_pulse", 64'(net_clear), 64'd1);
        chk("clear_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("clear_one_cycle", 64'(net_clear), 64'd0);
        chk("clear_ready_back", 64'(bus.cmd_ready), 64'd1);
        chk("clear_count", 64'(clr_cnt), 64'(cbase + 1));
        tick();
        exp_inp_q.push_back('0);
        push_done('0, 1'b1);
        send_cmd(OP_RUN, 0, 16'd1);
        wait_done(dbase + 4);
        repeat (2) tick();

        // 6: reset in the cycle of step 2 of RUN 5
        base  = en_cnt;
        dbase = done_cnt;
        exp_inp_q.push_back('0);
        send_cmd(OP_RUN, 0, 16'd5);
        wait_en(base + 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_blocks_step", 64'(net_en), 64'd0);
        tick();
        @(negedge clk);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_cmd_ready_in_rst", 64'(bus.cmd_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("abort_out_counts", 64'(bus.out_counts), 64'd0);
        repeat (10) tick();
        chk("abort_no_more_steps", 64'(en_cnt), 64'(base + 1));
        chk("abort_no_run_done", 64'(done_cnt), 64'(dbase));

        // All queued expectations consumed
        chk("inp_queue_empty", 64'(exp_inp_q.size()), 64'd0);
        chk("fire_queue_empty", 64'(exp_fire_q.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
